matmul_scheduler: RTL and testbench

//  Sequences one inner-product unit over every (row, column) pair of a ROWS x COLS result matrix.

---
 rtl/matmul_scheduler.sv | 143 ++++++++++++++
 tb/tb_matmul_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_scheduler.sv
// Walks one inner-product unit over every (row, col) of a ROWS x COLS result matrix,
// handshaking operands/results and writing each dot product to row*COLS+col.
module matmul_scheduler #(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLS    = 4,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic [RW-1:0] row_idx,
    output logic [CW-1:0] col_idx,
    output logic          ip_in_stb,
    input  logic          ip_in_ack,
    input  logic [31:0]   ip_res,
    input  logic          ip_res_stb,
    output logic          ip_res_ack,
    output logic          res_we,
    output logic [AW-1:0] res_addr,
    output logic [31:0]   res_data,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitRes,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   data_q, data_d;
    logic          last_row, last_col;

    assign last_row = (row_q == RW'(ROWS - 1));
    assign last_col = (col_q == CW'(COLS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            timer_q <= timer_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        timer_d = timer_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (ip_in_ack) begin
                    timer_d = '0;
                    state_d = StWaitRes;
                end
            end
            StWaitRes: begin
                // A result arriving on the timeout edge is still accepted.
                if (abort) begin
                    state_d = StIdle;
                end else if (ip_res_stb) begin
                    data_d  = ip_res;
                    state_d = StWrite;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = StError;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StWrite: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (last_row && last_col) begin
                    state_d = StDone;
                end else if (last_col) begin
                    col_d   = '0;
                    row_d   = row_q + RW'(1);
                    state_d = StIssue;
                end else begin
                    col_d   = col_q + CW'(1);
                    state_d = StIssue;
                end
            end
            StDone: begin
                row_d   = '0;
                col_d   = '0;
                state_d = StIdle;
            end
            StError: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign row_idx    = row_q;
    assign col_idx    = col_q;
    assign ip_in_stb  = (state_q == StIssue);
    assign ip_res_ack = (state_q == StWaitRes);
    assign res_we     = (state_q == StWrite);
    // Modular AW-bit arithmetic is exact because the true address is below ROWS*COLS.
    assign res_addr   = AW'(row_q) * AW'(COLS) + AW'(col_q);
    assign res_data   = data_q;
    assign busy       = (state_q == StIssue) || (state_q == StWaitRes) || (state_q == StWrite);
    assign done       = (state_q == StDone);
    assign error      = (state_q == StError);

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler on a 2x2 matrix with TIMEOUT=16.
module tb_matmul_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [0:0]  row_idx;
    logic [0:0]  col_idx;
    logic        ip_in_stb;
    logic        ip_in_ack;
    logic [31:0] ip_res;
    logic        ip_res_stb;
    logic        ip_res_ack;
    logic        res_we;
    logic [1:0]  res_addr;
    logic [31:0] res_data;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    // Inner-product unit stand-in: ack after ack_delay strobe cycles, result gated by res_en.
    int   ack_delay = 0;
    int   stb_cnt = 0;
    logic res_en = 1'b1;

    assign ip_in_ack  = (stb_cnt >= ack_delay);
    assign ip_res_stb = res_en;
    assign ip_res     = 32'hA0 + {30'd0, row_idx, col_idx};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ip_in_stb && !ip_in_ack) stb_cnt <= stb_cnt + 1;
        else stb_cnt <= 0;
    end

    matmul_scheduler #(
        .ROWS    (2),
        .COLS    (2),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .row_idx    (row_idx),
        .col_idx    (col_idx),
        .ip_in_stb  (ip_in_stb),
        .ip_in_ack  (ip_in_ack),
        .ip_res     (ip_res),
        .ip_res_stb (ip_res_stb),
        .ip_res_ack (ip_res_ack),
        .res_we     (res_we),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    int          nwr;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    int          wr_cyc  [16];
    int          done_cyc;
    int          err_cyc;
    int          stb_cycles;
    int          wait_cycles;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start pulse; on return the bench is in cycle 1 of the pass.
    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Observe cycles 1..budget, optionally pulsing abort/rst/start in a given cycle.
    task automatic run(input int budget, input int abort_at, input int rst_at,
                       input int start_at);
        nwr = 0; done_cyc = 0; err_cyc = 0; stb_cycles = 0; wait_cycles = 0;
        for (int n = 1; n <= budget; n++) begin
            if (ip_in_stb) stb_cycles++;
            if (ip_res_ack) wait_cycles++;
            if (res_we && nwr < 16) begin
                wr_addr[nwr] = 32'(res_addr);
                wr_data[nwr] = res_data;
                wr_cyc[nwr]  = n;
                nwr++;
            end
            if (error && err_cyc == 0) err_cyc = n;
            if (done) begin
                done_cyc = n;
                break;
            end
            abort = (n == abort_at);
            rst   = (n == rst_at);
            start = (n == start_at);
            step();
        end
        abort = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_full_pass(input string tag, input int elem_cycles);
        chk({tag, " writes"}, 32'(nwr), 32'd4);
        for (int i = 0; i < 4 && i < nwr; i++) begin
            chk($sformatf("%s addr%0d", tag, i), wr_addr[i], 32'(i));
            chk($sformatf("%s data%0d", tag, i), wr_data[i], 32'hA0 + 32'(i));
            chk($sformatf("%s wcyc%0d", tag, i), 32'(wr_cyc[i]), 32'(elem_cycles * (i + 1)));
        end
        chk({tag, " done_cyc"}, 32'(done_cyc), 32'(elem_cycles * 4 + 1));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " res_we"}, 32'(res_we), 32'd0);
        chk({tag, " in_stb"}, 32'(ip_in_stb), 32'd0);
        chk({tag, " res_ack"}, 32'(ip_res_ack), 32'd0);
    endtask

    initial begin
        step();
        step();
        // Reset state
        check_idle_outputs("rst");
        chk("rst error", 32'(error), 32'd0);
        chk("rst row", 32'(row_idx), 32'd0);
        chk("rst col", 32'(col_idx), 32'd0);
        chk("rst addr", 32'(res_addr), 32'd0);
        chk("rst data", res_data, 32'd0);
        rst = 1'b0;
        step();

        // 1: zero-wait unit, 3 cycles per element
        kick();
        run(40, 0, 0, 0);
        check_full_pass("t1", 3);
        chk("t1 stb_cycles", 32'(stb_cycles), 32'd4);
        step();
        check_idle_outputs("t1 after");

        // 2: ack delayed 5 cycles, strobe held 6 cycles per element
        ack_delay = 5;
        kick();
        run(60, 0, 0, 0);
        check_full_pass("t2", 8);
        chk("t2 stb_cycles", 32'(stb_cycles), 32'd24);
        ack_delay = 0;
        step();

        // 3: no result ever -> error after 16 WAIT_RES cycles, then start recovers
        res_en = 1'b0;
        kick();
        run(25, 0, 0, 0);
        chk("t3 wait_cycles", 32'(wait_cycles), 32'd16);
        chk("t3 err_cyc", 32'(err_cyc), 32'd18);
        chk("t3 writes", 32'(nwr), 32'd0);
        chk("t3 error", 32'(error), 32'd1);
        chk("t3 busy", 32'(busy), 32'd0);
        res_en = 1'b1;
        kick();
        chk("t3 error cleared", 32'(error), 32'd0);
        chk("t3 restart stb", 32'(ip_in_stb), 32'd1);
        run(40, 0, 0, 0);
        check_full_pass("t3r", 3);
        step();

        // 4: abort in WAIT_RES of element 2 (cycle 8)
        kick();
        run(8, 8, 0, 0);
        chk("t4 writes", 32'(nwr), 32'd2);
        chk("t4 addr0", wr_addr[0], 32'd0);
        chk("t4 addr1", wr_addr[1], 32'd1);
        chk("t4 wait_cycles", 32'(wait_cycles), 32'd3);
        check_idle_outputs("t4 post");
        chk("t4 error", 32'(error), 32'd0);
        run(10, 0, 0, 0);
        chk("t4 idle writes", 32'(nwr), 32'd0);
        chk("t4 idle done", 32'(done_cyc), 32'd0);

        // 5: rst pulsed during WRITE of element 1 (cycle 6)
        kick();
        run(6, 0, 6, 0);
        chk("t5 writes", 32'(nwr), 32'd2);
        chk("t5 wcyc1", 32'(wr_cyc[1]), 32'd6);
        check_idle_outputs("t5 post");
        chk("t5 row", 32'(row_idx), 32'd0);
        chk("t5 col", 32'(col_idx), 32'd0);
        chk("t5 addr", 32'(res_addr), 32'd0);
        chk("t5 data", res_data, 32'd0);
        step();
        kick();
        run(40, 0, 0, 0);
        check_full_pass("t5r", 3);
        step();

        // 6: start re-pulsed mid-pass, result strobe high during ISSUE
        kick();
        run(40, 0, 0, 5);
        check_full_pass("t6", 3);
        step();
        check_idle_outputs("t6 after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
